i2c_slave_responder: RTL and testbench
======================================

Name: i2c_slave_responder

Overview:
- Synthesizable I2C slave that responds to the IICMB master on one I2C bus.
- Detects START and STOP conditions, matches a 7-bit address, and ACKs its address and every written byte.
- Holds a small byte-addressed register file with a pointer-then-data write convention and auto-increment reads.
- Has a host-side port so testbenches and system logic can preload and inspect the register file.

Parameters:
- SLAVE_ADDR, 7'h22, 7-bit I2C address this slave answers to.
- DEPTH, 16, number of 8-bit registers; power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer/host address width; derived, not overridden.

Ports:
- clk_i  in  1  system clock; must be at least 10x SCL frequency.
- rst_i  in  1  asynchronous, active-high reset.
- scl_i  in  1  I2C clock, resolved wired-AND bus value.
- sda_i  in  1  I2C data, resolved wired-AND bus value.
- scl_o  out  1  constant 1 (released); no clock stretching.
- sda_o  out  1  0 = pull low, 1 = release.
- host_we_i  in  1  host write strobe.
- host_addr_i  in  AW  host register address.
- host_wdata_i  in  8  host write data.
- host_rdata_o  out  8  mem[host_addr_i], registered, 1-cycle latency.
- wr_evt_o  out  1  one-cycle pulse when an I2C data byte is written into mem.
- wr_addr_o  out  AW  register address of that write.
- wr_data_o  out  8  data of that write.
- busy_o  out  1  high from an address match until STOP, repeated START, or master NACK.

Behaviour:
- Reset values: sda_o=1, scl_o=1, wr_evt_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, host_rdata_o=0, ptr=0, state=IDLE, synchronizers=1.
- mem contents are not reset.
- Asserting rst_i mid-transfer releases sda_o immediately (asynchronous).
- Input path: scl_i and sda_i each pass through a 2-flop synchronizer, then a 1-flop edge detect.
- scl_rise / scl_fall / sda_rise / sda_fall are one-cycle pulses, 3 clk after the raw edge.
- START = sda_fall while synced scl=1. From any state: go to ADDR, bit_cnt=0, release sda_o. This also covers repeated START.
- STOP = sda_rise while synced scl=1. From any state: go to IDLE, release sda_o, busy_o=0.
- Data bits are sampled on scl_rise, MSB first. sda_o changes only on the cycle after scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After the 8th scl_rise:
    - addr[7:1]==SLAVE_ADDR → latch R/W, busy_o=1, go to ADDR_ACK.
    - otherwise → go to IGNORE.
  - IGNORE: sda_o released; wait for START or STOP.
  - ADDR_ACK: on scl_fall drive sda_o=0. On the next scl_fall:
    - write → release sda_o, go to WR_DATA, first_byte=1.
    - read → load mem[ptr] into the shift register, drive its MSB, ptr++, go to RD_DATA.
  - WR_DATA: shift 8 bits, then go to WR_ACK.
    - If first_byte: ptr = byte[AW-1:0] (upper bits ignored), first_byte=0.
    - Else: mem[ptr]=byte; pulse wr_evt_o with wr_addr_o=ptr and wr_data_o=byte; ptr++.
  - WR_ACK: drive sda_o=0 from scl_fall to the next scl_fall, then release and return to WR_DATA.
  - RD_DATA: on each scl_fall drive the next bit. After the 8th bit's scl_fall, release sda_o and go to RD_ACK.
  - RD_ACK: sample master ACK on scl_rise.
    - ACK (0) → on scl_fall load mem[ptr], ptr++, return to RD_DATA.
    - NACK (1) → go to IGNORE, busy_o=0.
- Pointer wraps modulo DEPTH (DEPTH-1 → 0). ptr persists across transactions; it is not cleared by STOP.
- Simultaneous host write and I2C write to the same cycle/address: the host write wins and the I2C byte is dropped. wr_evt_o still pulses.
- Host read returns the pre-write value on a same-cycle collision.
- Glitch rule: SDA transitions while SCL is high during a data phase count only as START/STOP. They always abort the byte in flight.
- Undriven bus: scl_i/sda_i idle at 1 through tri1/pullups, so no false START occurs.

Decomposition:
- Package i2c_slave_pkg:
  - state enum: IDLE, ADDR, ADDR_ACK, IGNORE, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - constants: I2C_RELEASE=1'b1, I2C_DRIVE_LOW=1'b0, BITS_PER_BYTE=8.
- Sub-module i2c_sync_edge: 2-flop synchronizer plus rise/fall pulse, instantiated once each for scl and sda.
- The register file is inferred inside the top module.

Test Plan:
- Addressed write: IICMB sends START, 0x44, 0x03, 0x78, STOP → ACK on all three bytes; wr_evt_o pulses once with addr=3, data=0x78; host read of addr 3 returns 0x78; busy_o falls at STOP.
- Address mismatch: START, 0x46, STOP → no ACK (IICMB reports NAK); sda_o stays 1 throughout; no wr_evt_o.
- Pointer set then read: host preloads mem[14]=0xA5 and mem[15]=0x5A. Sequence: START, 0x44, 0x0E, repeated START, 0x45, read with ACK, read with NACK, STOP → bytes 0xA5 then 0x5A returned; final ptr=0 (wrap).
- Write wrap: pointer 15, then data 0x11, 0x22 → mem[15]=0x11, mem[0]=0x22; two wr_evt_o pulses with addresses 15 then 0.
- Reset mid-read: assert rst_i while driving a 0 data bit → sda_o=1 within the same cycle; state=IDLE; next START/0x44 is ACKed normally.
- Host collision: host_we_i to addr 2 with 0xEE on the same cycle the I2C byte 0x33 commits to addr 2 → mem[2]=0xEE; wr_evt_o reports 0x33.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// ----------------------------------------------------------------------------
// i2c_slave_pkg
// Shared types and constants for the I2C slave responder: the protocol FSM
// state encoding and the open-drain drive levels used on SDA.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    IGNORE,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_e;

  localparam logic I2C_RELEASE   = 1'b1;
  localparam logic I2C_DRIVE_LOW = 1'b0;
  localparam int   BITS_PER_BYTE = 8;

  // Bit counter value on the last bit of a byte.
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

endpackage

// File: rtl/i2c_sync_edge.sv
// ----------------------------------------------------------------------------
// i2c_sync_edge
// Two-flop synchronizer for an asynchronous bus line followed by a one-flop
// edge detector.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset (all stages reset to 1 = idle bus)
//   d_i     : raw asynchronous input
//   level_o : synchronized level
//   rise_o  : one-cycle pulse on a 0->1 transition of the synchronized level
//   fall_o  : one-cycle pulse on a 1->0 transition of the synchronized level
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;
  assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// i2c_slave_responder
// I2C slave with a byte-addressed register file. The first byte of a write
// sets the register pointer; further written bytes are stored at the pointer
// with auto-increment. Reads return mem[ptr] with auto-increment until the
// master NACKs. The pointer wraps modulo DEPTH and survives STOP.
//   clk_i, rst_i       : system clock (>= 10x SCL), async active-high reset
//   scl_i, sda_i       : resolved bus values
//   scl_o              : always released (no clock stretching)
//   sda_o              : 0 = pull low, 1 = release
//   host_we_i/addr/wdata : host write port (wins over a same-address I2C write)
//   host_rdata_o       : mem[host_addr_i], registered
//   wr_evt_o/addr/data : one-cycle report of each I2C data byte written
//   busy_o             : addressed transaction in progress
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter  logic [6:0] SLAVE_ADDR = 7'h22,
  parameter  int         DEPTH      = 16,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          scl_o,
  output logic          sda_o,
  input  logic          host_we_i,
  input  logic [AW-1:0] host_addr_i,
  input  logic [7:0]    host_wdata_i,
  output logic [7:0]    host_rdata_o,
  output logic          wr_evt_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [7:0]    wr_data_o,
  output logic          busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(scl_i),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk_i(clk_i), .rst_i(rst_i), .d_i(sda_i),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // SDA moving while SCL is high is always a bus condition, never data.
  logic start_cond, stop_cond;
  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;

  logic [7:0] mem [DEPTH];

  state_e        state_q,   state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q,   shift_d;
  logic          rw_q,      rw_d;
  logic          first_q,   first_d;
  logic          phase_q,   phase_d;   // ack slot: low already driven / master ACK seen
  logic [AW-1:0] ptr_q,     ptr_d;
  logic          sda_q,     sda_d;
  logic          busy_q,    busy_d;
  logic          wr_evt_q,  wr_evt_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    host_rdata_q, host_rdata_d;

  logic [7:0] rx_byte, rd_word;
  assign rx_byte = {shift_q[6:0], sda_lvl};
  assign rd_word = mem[ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rw_d         = rw_q;
    first_d      = first_q;
    phase_d      = phase_q;
    ptr_d        = ptr_q;
    sda_d        = sda_q;
    busy_d       = busy_q;
    wr_evt_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    host_rdata_d = mem[host_addr_i];

    if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_d     = I2C_RELEASE;
      busy_d    = 1'b0;
    end else if (stop_cond) begin
      state_d = IDLE;
      sda_d   = I2C_RELEASE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            if (shift_q[6:0] == SLAVE_ADDR) begin
              rw_d    = sda_lvl;
              busy_d  = 1'b1;
              phase_d = 1'b0;
              state_d = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_d   = I2C_DRIVE_LOW;
            phase_d = 1'b1;
          end else if (rw_q) begin
            shift_d   = rd_word;
            sda_d     = rd_word[7];
            ptr_d     = ptr_q + 1'b1;
            bit_cnt_d = '0;
            state_d   = RD_DATA;
          end else begin
            sda_d     = I2C_RELEASE;
            first_d   = 1'b1;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            if (first_q) begin
              ptr_d   = rx_byte[AW-1:0];
              first_d = 1'b0;
            end else begin
              wr_evt_d  = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = rx_byte;
              ptr_d     = ptr_q + 1'b1;
            end
            phase_d = 1'b0;
            state_d = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_d   = I2C_DRIVE_LOW;
            phase_d = 1'b1;
          end else begin
            sda_d     = I2C_RELEASE;
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == LAST_BIT) begin
            sda_d   = I2C_RELEASE;
            phase_d = 1'b0;
            state_d = RD_ACK;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_d     = shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl) begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            shift_d   = rd_word;
            sda_d     = rd_word[7];
            ptr_d     = ptr_q + 1'b1;
            bit_cnt_d = '0;
            state_d   = RD_DATA;
          end
        end
        default: ;  // IDLE, IGNORE: only START/STOP move us on
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      first_q      <= 1'b0;
      phase_q      <= 1'b0;
      ptr_q        <= '0;
      sda_q        <= I2C_RELEASE;
      busy_q       <= 1'b0;
      wr_evt_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rw_q         <= rw_d;
      first_q      <= first_d;
      phase_q      <= phase_d;
      ptr_q        <= ptr_d;
      sda_q        <= sda_d;
      busy_q       <= busy_d;
      wr_evt_q     <= wr_evt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // NOTE: the register file has no reset so it maps onto plain RAM/flops
  // without a reset tree; its contents are defined only once written.
  // The I2C byte commits during its wr_evt_o cycle; the host write is issued
  // second so it wins a same-address collision.
  always_ff @(posedge clk_i) begin
    if (wr_evt_q)  mem[wr_addr_q]   <= wr_data_q;
    if (host_we_i) mem[host_addr_i] <= host_wdata_i;
  end

  assign scl_o        = I2C_RELEASE;
  assign sda_o        = sda_q;
  assign busy_o       = busy_q;
  assign wr_evt_o     = wr_evt_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign host_rdata_o = host_rdata_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_responder
// Bit-banged I2C master driving the responder over a wired-AND bus. Expected
// register writes are queued as each byte is sent; a monitor pops and compares
// them whenever wr_evt_o pulses. ACKs, read data, busy_o and host reads are
// compared directly against hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_responder;

  localparam int Q = 100;  // quarter SCL period in ns (10 system clocks)

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_o, sda_o;
  logic       scl_bus, sda_bus;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic       wr_evt;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];
  logic sda_low_seen;
  logic seen;
  logic ack;
  logic [7:0] rd;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_slave_responder dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_bus), .sda_i(sda_bus),
    .scl_o(scl_o), .sda_o(sda_o),
    .host_we_i(host_we), .host_addr_i(host_addr), .host_wdata_i(host_wdata),
    .host_rdata_o(host_rdata),
    .wr_evt_o(wr_evt), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor for the write-event stream.
  always @(negedge clk) begin
    if (!rst && wr_evt) begin
      wr_t e;
      check("wr_evt_pending", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_evt_addr", {28'b0, wr_addr}, {28'b0, e.addr});
        check("wr_evt_data", {24'b0, wr_data}, {24'b0, e.data});
      end
    end
  end

  always @(negedge clk) if (sda_o == 1'b0) sda_low_seen <= 1'b1;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master primitives ----------------
  task automatic i2c_start;
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b0; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; #(Q); scl_m = 1'b1; #(Q); sda_m = 1'b1; #(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #(Q); scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #(Q); scl_m = 1'b1; #(Q); b = sda_bus; #(Q); scl_m = 1'b0; #(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    acked = ~b;
  endtask

  task automatic get_byte(output logic [7:0] d, input logic give_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(~give_ack);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(posedge clk);
    #1 d = host_rdata;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    sda_low_seen = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sda_o", {31'b0, sda_o}, 32'd1);
    check("rst_scl_o", {31'b0, scl_o}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_wr_evt", {31'b0, wr_evt}, 32'd0);
    check("rst_wr_addr", {28'b0, wr_addr}, 32'd0);
    check("rst_wr_data", {24'b0, wr_data}, 32'd0);
    check("rst_host_rdata", {24'b0, host_rdata}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Addressed write: pointer 3, data 0x78.
    exp_q.push_back('{addr: 4'd3, data: 8'h78});
    i2c_start;
    put_byte(8'h44, ack); check("wr_addr_ack", {31'b0, ack}, 32'd1);
    check("wr_busy_high", {31'b0, busy}, 32'd1);
    put_byte(8'h03, ack); check("wr_ptr_ack", {31'b0, ack}, 32'd1);
    put_byte(8'h78, ack); check("wr_data_ack", {31'b0, ack}, 32'd1);
    i2c_stop;
    repeat (10) @(negedge clk);
    check("wr_busy_low_after_stop", {31'b0, busy}, 32'd0);
    host_read(4'd3, rd); check("host_rd_3", {24'b0, rd}, 32'h78);

    // Address mismatch: no ACK, SDA never pulled.
    sda_low_seen = 1'b0;
    i2c_start;
    put_byte(8'h46, ack); check("mismatch_nak", {31'b0, ack}, 32'd0);
    check("mismatch_busy", {31'b0, busy}, 32'd0);
    i2c_stop;
    repeat (10) @(negedge clk);
    check("mismatch_sda_quiet", {31'b0, sda_low_seen}, 32'd0);

    // Pointer set, repeated START, read two bytes across the wrap.
    host_write(4'd14, 8'hA5);
    host_write(4'd15, 8'h5A);
    host_write(4'd0,  8'h3C);
    i2c_start;
    put_byte(8'h44, ack); check("rd_wr_addr_ack", {31'b0, ack}, 32'd1);
    put_byte(8'h0E, ack); check("rd_ptr_ack", {31'b0, ack}, 32'd1);
    i2c_start;
    put_byte(8'h45, ack); check("rd_addr_ack", {31'b0, ack}, 32'd1);
    get_byte(rd, 1'b1); check("rd_byte_14", {24'b0, rd}, 32'hA5);
    get_byte(rd, 1'b0); check("rd_byte_15", {24'b0, rd}, 32'h5A);
    check("rd_busy_low_after_nack", {31'b0, busy}, 32'd0);
    i2c_stop;
    // Pointer wrapped to 0: a fresh read returns mem[0].
    i2c_start;
    put_byte(8'h45, ack); check("rd2_addr_ack", {31'b0, ack}, 32'd1);
    get_byte(rd, 1'b0); check("rd_wrapped_ptr0", {24'b0, rd}, 32'h3C);
    i2c_stop;

    // Write wrap: pointer 15, then 0x11 at 15 and 0x22 at 0.
    exp_q.push_back('{addr: 4'd15, data: 8'h11});
    exp_q.push_back('{addr: 4'd0,  data: 8'h22});
    i2c_start;
    put_byte(8'h44, ack); check("wrap_addr_ack", {31'b0, ack}, 32'd1);
    put_byte(8'h0F, ack); check("wrap_ptr_ack", {31'b0, ack}, 32'd1);
    put_byte(8'h11, ack); check("wrap_d0_ack", {31'b0, ack}, 32'd1);
    put_byte(8'h22, ack); check("wrap_d1_ack", {31'b0, ack}, 32'd1);
    i2c_stop;
    host_read(4'd15, rd); check("host_rd_15", {24'b0, rd}, 32'h11);
    host_read(4'd0,  rd); check("host_rd_0",  {24'b0, rd}, 32'h22);

    // Host collision: host writes addr 2 in the cycle the I2C byte commits.
    exp_q.push_back('{addr: 4'd2, data: 8'h33});
    i2c_start;
    put_byte(8'h44, ack); check("coll_addr_ack", {31'b0, ack}, 32'd1);
    put_byte(8'h02, ack); check("coll_ptr_ack", {31'b0, ack}, 32'd1);
    seen = 1'b0;
    fork
      put_byte(8'h33, ack);
      begin
        for (int i = 0; i < 2000 && !seen; i++) begin
          @(negedge clk);
          seen = wr_evt;
        end
        check("coll_evt_seen", {31'b0, seen}, 32'd1);
        if (seen) begin
          host_addr = 4'd2; host_wdata = 8'hEE; host_we = 1'b1;
          @(negedge clk);
          host_we = 1'b0;
        end
      end
    join
    check("coll_data_ack", {31'b0, ack}, 32'd1);
    i2c_stop;
    host_read(4'd2, rd); check("coll_host_wins", {24'b0, rd}, 32'hEE);

    // Reset while the slave drives a 0 data bit.
    host_write(4'd5, 8'h00);
    i2c_start;
    put_byte(8'h44, ack); check("rstrd_wr_addr_ack", {31'b0, ack}, 32'd1);
    put_byte(8'h05, ack); check("rstrd_ptr_ack", {31'b0, ack}, 32'd1);
    i2c_start;
    put_byte(8'h45, ack); check("rstrd_rd_addr_ack", {31'b0, ack}, 32'd1);
    check("rstrd_driving_zero", {31'b0, sda_o}, 32'd0);
    #3 rst = 1'b1;
    #1 check("rstrd_sda_released", {31'b0, sda_o}, 32'd1);
    check("rstrd_busy_cleared", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    i2c_start;
    put_byte(8'h44, ack); check("post_rst_addr_ack", {31'b0, ack}, 32'd1);
    i2c_stop;
    repeat (10) @(negedge clk);

    check("wr_queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
